// File: rtl/instr_sequencer_if.sv
// Fetch/execute handshake between the program sequencer and the fetch/exec units.
interface instr_sequencer_if #(
    parameter int unsigned OPC_WIDTH = 5
);
    logic                 fetch_en;
    logic                 fetch_done;
    logic [OPC_WIDTH-1:0] opcode;
    logic                 exec_start;
    logic                 exec_done;

    modport master (
        output fetch_en,
        output exec_start,
        input  fetch_done,
        input  opcode,
        input  exec_done
    );

    modport slave (
        input  fetch_en,
        input  exec_start,
        output fetch_done,
        output opcode,
        output exec_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: fetch -> decode -> dispatch -> wait loop with watchdogs,
// illegal-opcode trap, instruction budget and result-capture strobe.
module instr_sequencer #(
    parameter int unsigned OPC_WIDTH      = 5,
    parameter int unsigned HALT_OPCODE    = 0,
    parameter int unsigned MAX_OPCODE     = 7,
    parameter int unsigned CAPTURE_OPCODE = 6,
    parameter int unsigned MAX_INSTR      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    instr_sequencer_if.master    bus,
    output logic                 result_capture,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           error_code,
    output logic [CNT_WIDTH-1:0] instr_count
);
    localparam int unsigned WD_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_DISPATCH  = 3'd3;
    localparam logic [2:0] S_WAIT_EXEC = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    localparam logic [1:0] EC_NONE    = 2'd0;
    localparam logic [1:0] EC_FETCH   = 2'd1;
    localparam logic [1:0] EC_EXEC    = 2'd2;
    localparam logic [1:0] EC_ILLEGAL = 2'd3;

    logic [2:0]           state_q, state_d;
    logic [WD_WIDTH-1:0]  wd_q, wd_d;
    logic [OPC_WIDTH-1:0] opc_q, opc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d, count_inc;
    logic [1:0]           ecode_q, ecode_d;
    logic                 fetch_en_q, fetch_en_d;
    logic                 exec_start_q, exec_start_d;
    logic                 capture_q, capture_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 wd_expired;

    // Next-state, counters and registered-output precomputation.
    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        count_d    = count_q;
        ecode_d    = ecode_q;
        capture_d  = 1'b0;
        wd_expired = (wd_q == WD_WIDTH'(TIMEOUT_CYCLES - 1));
        count_inc  = (count_q < CNT_WIDTH'(MAX_INSTR)) ? count_q + CNT_WIDTH'(1) : count_q;

        case (state_q)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    count_d = '0;
                    ecode_d = EC_NONE;
                end
            end
            S_FETCH: begin
                if (bus.fetch_done) begin
                    state_d = S_DECODE;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                    ecode_d = EC_FETCH;
                end
            end
            S_DECODE: begin
                if (bus.opcode == OPC_WIDTH'(HALT_OPCODE)) begin
                    state_d = S_FINISH;
                end else if (bus.opcode > OPC_WIDTH'(MAX_OPCODE)) begin
                    state_d = S_ERROR;
                    ecode_d = EC_ILLEGAL;
                end else begin
                    opc_d   = bus.opcode;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                state_d = S_WAIT_EXEC;
            end
            S_WAIT_EXEC: begin
                if (bus.exec_done) begin
                    count_d   = count_inc;
                    capture_d = (opc_q == OPC_WIDTH'(CAPTURE_OPCODE));
                    state_d   = (count_inc == CNT_WIDTH'(MAX_INSTR)) ? S_FINISH : S_FETCH;
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                    ecode_d = EC_EXEC;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition and handshake in the same cycle.
        if (abort) begin
            state_d   = S_IDLE;
            count_d   = '0;
            ecode_d   = EC_NONE;
            capture_d = 1'b0;
        end

        // Watchdog restarts on every state entry and only runs while waiting.
        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_WAIT_EXEC))) begin
            wd_d = wd_q + WD_WIDTH'(1);
        end else begin
            wd_d = '0;
        end

        fetch_en_d   = (state_d == S_FETCH);
        exec_start_d = (state_d == S_DISPATCH);
        done_d       = (state_d == S_FINISH);
        error_d      = (state_d == S_ERROR);
        busy_d       = !((state_d == S_IDLE) || (state_d == S_FINISH) || (state_d == S_ERROR));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            opc_q        <= '0;
            count_q      <= '0;
            ecode_q      <= EC_NONE;
            fetch_en_q   <= 1'b0;
            exec_start_q <= 1'b0;
            capture_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            opc_q        <= opc_d;
            count_q      <= count_d;
            ecode_q      <= ecode_d;
            fetch_en_q   <= fetch_en_d;
            exec_start_q <= exec_start_d;
            capture_q    <= capture_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.fetch_en   = fetch_en_q;
    assign bus.exec_start = exec_start_q;
    assign result_capture = capture_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign error_code     = ecode_q;
    assign instr_count    = count_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random programs checked
// against a transaction-level model of the program run.
module tb_instr_sequencer;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned MAX_OPC = 7;
    localparam int unsigned CAP_OPC = 6;
    localparam int unsigned MAX_I   = 3;
    localparam int unsigned TMO     = 16;
    localparam int unsigned CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             result_capture;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       error_code;
    logic [CNT_W-1:0] instr_count;

    instr_sequencer_if #(.OPC_WIDTH(OPC_W)) sif ();

    instr_sequencer #(
        .OPC_WIDTH(OPC_W), .HALT_OPCODE(0), .MAX_OPCODE(MAX_OPC),
        .CAPTURE_OPCODE(CAP_OPC), .MAX_INSTR(MAX_I), .TIMEOUT_CYCLES(TMO),
        .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(sif),
        .result_capture(result_capture), .busy(busy), .done(done), .error(error),
        .error_code(error_code), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Program description consumed by the responders (index = fetch number).
    int prog_opc [8];
    int fdly     [8];
    int edly     [8];
    bit spur_exec  = 1'b0;
    bit spur_fetch = 1'b0;
    int fidx = 0;
    int eidx = 0;
    int fd_cyc = 0;
    int ed_cyc = 0;

    // Observed activity during a run.
    int n_exec  = 0;
    int n_cap   = 0;
    int n_fetch = 0;
    int n_fcyc  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rand_dly();
        int k;
        k = int'($urandom_range(0, 19));
        if (k < 16) return int'($urandom_range(0, 4));
        if (k < 18) return TMO - 1;
        return TMO + int'($urandom_range(0, 3));
    endfunction

    function automatic int rand_opc();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 0;
        if (k == 1) return int'($urandom_range(MAX_OPC + 1, 31));
        return int'($urandom_range(1, MAX_OPC));
    endfunction

    task automatic set_prog(input int o0, input int o1, input int o2, input int o3,
                            input int f, input int e);
        for (int i = 0; i < 8; i++) begin
            prog_opc[i] = 0;
            fdly[i]     = f;
            edly[i]     = e;
        end
        prog_opc[0] = o0;
        prog_opc[1] = o1;
        prog_opc[2] = o2;
        prog_opc[3] = o3;
    endtask

    // Fetch unit: answers fetch_en after fdly[] cycles with the next opcode.
    initial begin : fetch_resp
        int fcyc;
        fcyc = 0;
        sif.fetch_done = 1'b0;
        sif.opcode     = '0;
        forever begin
            @(negedge clk);
            sif.fetch_done = 1'b0;
            if (rst || !sif.fetch_en) begin
                fcyc = 0;
                if (spur_fetch && busy && !rst) sif.fetch_done = 1'($urandom_range(0, 1));
            end else begin
                if (fidx < 8 && fcyc == fdly[fidx]) begin
                    sif.fetch_done = 1'b1;
                    sif.opcode     = OPC_W'(prog_opc[fidx]);
                    fd_cyc         = cyc;
                    fidx++;
                end
                fcyc++;
            end
        end
    end

    // Execution unit: answers exec_start after edly[] waiting cycles.
    initial begin : exec_resp
        int ecyc;
        ecyc = -1;
        sif.exec_done = 1'b0;
        forever begin
            @(negedge clk);
            sif.exec_done = 1'b0;
            if (rst || !busy) begin
                ecyc = -1;
            end else if (sif.exec_start) begin
                ecyc = 0;
            end else if (ecyc >= 0) begin
                if (eidx < 8 && ecyc == edly[eidx]) begin
                    sif.exec_done = 1'b1;
                    ed_cyc        = cyc;
                    eidx++;
                    ecyc = -1;
                end else begin
                    ecyc++;
                end
            end
            if (!sif.exec_done && spur_exec && sif.fetch_en && !rst)
                sif.exec_done = 1'($urandom_range(0, 1));
        end
    end

    // Pulse monitor with latency checks on dispatch and capture.
    initial begin : monitor
        logic fe_prev;
        fe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sif.exec_start) begin
                    n_exec++;
                    check("fetch_to_dispatch", 64'(cyc - fd_cyc), 64'd2);
                end
                if (result_capture) begin
                    n_cap++;
                    check("capture_lag", 64'(cyc - ed_cyc), 64'd1);
                end
                if (sif.fetch_en) n_fcyc++;
                if (sif.fetch_en && !fe_prev) n_fetch++;
            end
            fe_prev = sif.fetch_en;
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({sif.fetch_en, sif.exec_start, result_capture, busy, done, error,
                    error_code, instr_count});
    endfunction

    task automatic clear_run();
        fidx = 0; eidx = 0;
        n_exec = 0; n_cap = 0; n_fetch = 0; n_fcyc = 0;
    endtask

    // Run one program to completion and compare with the transaction model.
    task automatic run_prog(input string tag);
        int  e_fetch, e_fcyc, e_exec, e_cap, e_cnt, e_code, waited;
        bit  e_done, e_err;
        e_fetch = 0; e_fcyc = 0; e_exec = 0; e_cap = 0; e_cnt = 0; e_code = 0;
        e_done = 1'b0; e_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e_fetch++;
            if (fdly[i] >= int'(TMO)) begin e_fcyc += TMO; e_err = 1'b1; e_code = 1; break; end
            e_fcyc += fdly[i] + 1;
            if (prog_opc[i] == 0) begin e_done = 1'b1; break; end
            if (prog_opc[i] > int'(MAX_OPC)) begin e_err = 1'b1; e_code = 3; break; end
            e_exec++;
            if (edly[i] >= int'(TMO)) begin e_err = 1'b1; e_code = 2; break; end
            e_cnt++;
            if (prog_opc[i] == int'(CAP_OPC)) e_cap++;
            if (e_cnt == int'(MAX_I)) begin e_done = 1'b1; break; end
        end

        clear_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_state"}, 64'({sif.fetch_en, busy, done, error, error_code, instr_count}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0}));
        waited = 0;
        while (!(done || error) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_terminates"}, 64'(waited < 1000), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_done"},        64'(done),        64'(e_done));
        check({tag, "_error"},       64'(error),       64'(e_err));
        check({tag, "_error_code"},  64'(error_code),  64'(e_code));
        check({tag, "_instr_count"}, 64'(instr_count), 64'(e_cnt));
        check({tag, "_busy"},        64'(busy),        64'd0);
        check({tag, "_dispatches"},  64'(n_exec),      64'(e_exec));
        check({tag, "_captures"},    64'(n_cap),       64'(e_cap));
        check({tag, "_fetches"},     64'(n_fetch),     64'(e_fetch));
        check({tag, "_fetch_cycles"}, 64'(n_fcyc),     64'(e_fcyc));
    endtask

    task automatic wait_dispatch(output int waited);
        waited = 0;
        while (!sif.exec_start && waited < 200) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin : main
        int waited, snap_exec;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_prog(1, 1, 1, 1, 1, 1);
        @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", all_outs(), 64'd0);

        // Opcodes 1, 6, HALT with spurious exec_done during FETCH.
        set_prog(1, 6, 0, 0, 2, 4);
        spur_exec = 1'b1;
        run_prog("three_instr");
        spur_exec = 1'b0;

        // Budget exhaustion.
        set_prog(1, 1, 1, 1, 0, 0);
        fdly[1] = 3; edly[2] = 2;
        run_prog("budget");

        // Fetch watchdog, then recovery by start.
        set_prog(1, 1, 1, 1, 100, 1);
        run_prog("fetch_timeout");
        set_prog(6, 0, 0, 0, TMO - 1, TMO - 1);
        run_prog("tie_recover");

        // Exec watchdog and illegal opcode.
        set_prog(2, 1, 1, 1, 1, 100);
        run_prog("exec_timeout");
        set_prog(9, 1, 1, 1, 1, 1);
        run_prog("illegal");

        // Abort on the same cycle as exec_done of a capture opcode.
        set_prog(6, 6, 6, 6, 1, 3);
        clear_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dispatch(waited);
        check("abort_dispatch_seen", 64'(waited < 200), 64'd1);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_tie_align", 64'(sif.exec_done), 64'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_state", 64'({sif.fetch_en, busy, done, error, error_code, instr_count}), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_no_capture", 64'(n_cap), 64'd0);
        check("abort_count", 64'(instr_count), 64'd0);

        // Asynchronous reset while dispatching.
        set_prog(1, 1, 1, 1, 1, 2);
        clear_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dispatch(waited);
        check("rst_dispatch_seen", 64'(waited < 200), 64'd1);
        snap_exec = n_exec;
        rst = 1'b1;
        #1;
        check("rst_immediate", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_quiet", all_outs(), 64'd0);
        check("rst_no_pulses", 64'(n_exec), 64'(snap_exec));

        // Random programs.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 8; i++) begin
                prog_opc[i] = rand_opc();
                fdly[i]     = rand_dly();
                edly[i]     = rand_dly();
            end
            spur_exec  = 1'($urandom_range(0, 1));
            spur_fetch = 1'($urandom_range(0, 1));
            run_prog("rand");
        end
        spur_exec  = 1'b0;
        spur_fetch = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
